// File: rtl/dmem_bus_pkg.sv
// Shared types for the core data-memory bus: port ids and request payload.
package dmem_bus_pkg;

   localparam int XLEN   = 64;
   localparam int STRB_W = XLEN / 8;

   typedef logic port_id_t;

   localparam port_id_t PORT_DMEM = 1'b0;
   localparam port_id_t PORT_MMIO = 1'b1;

   typedef struct packed {
      logic [XLEN-1:0]   addr;
      logic              we;
      logic [XLEN-1:0]   wdata;
      logic [STRB_W-1:0] wstrb;
   } dmem_req_t;

   function automatic port_id_t other_port(input port_id_t p);
      return ~p;
   endfunction

endpackage

// File: rtl/dmem_outstanding_tracker.sv
// In-flight request bookkeeping for the 1x2 demux: count, owning port
// and a sticky flag for responses that arrive from the wrong place.
module dmem_outstanding_tracker
   import dmem_bus_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fire,
   input  port_id_t   t,
   input  logic [1:0] rsp_valid,
   output logic       allow,
   output port_id_t   rsp_sel,
   output logic       rsp,
   output logic       err
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

   logic [CW-1:0] cnt;
   port_id_t      own;
   logic          err_q;
   logic          busy;
   logic          full;
   logic          stray;

   always_comb begin
      busy  = (cnt != '0);
      full  = (cnt == CNT_MAX);
      allow = !busy || ((t == own) && !full);
      rsp   = busy && rsp_valid[own];
      // With nothing in flight, any response at all is unexpected.
      stray = busy ? rsp_valid[other_port(own)] : (rsp_valid != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         own   <= PORT_DMEM;
         err_q <= 1'b0;
      end else begin
         if (fire) begin
            own <= t;
         end
         if (stray) begin
            err_q <= 1'b1;
         end
         unique case ({fire, rsp})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign rsp_sel = own;
   assign err     = err_q;

   a_cnt_bound: assert property (@(posedge clk) cnt <= CNT_MAX);

endmodule

// File: rtl/dmem_req_demux_1x2.sv
// Steers one LSU request stream to DMEM or MMIO by an address bit and
// merges the two response streams back in request order.
module dmem_req_demux_1x2
   import dmem_bus_pkg::*;
#(
   parameter int ADDR_WIDTH      = 64,
   parameter int DATA_WIDTH      = 64,
   parameter int SEL_BIT         = 28,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,

   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic [ADDR_WIDTH-1:0]   i_req_addr,
   input  logic                    i_req_we,
   input  logic [DATA_WIDTH-1:0]   i_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_req_wstrb,

   output logic                    o_p0_req_valid,
   input  logic                    i_p0_req_ready,
   output logic [ADDR_WIDTH-1:0]   o_p0_req_addr,
   output logic                    o_p0_req_we,
   output logic [DATA_WIDTH-1:0]   o_p0_req_wdata,
   output logic [DATA_WIDTH/8-1:0] o_p0_req_wstrb,
   input  logic                    i_p0_rsp_valid,
   input  logic [DATA_WIDTH-1:0]   i_p0_rsp_rdata,

   output logic                    o_p1_req_valid,
   input  logic                    i_p1_req_ready,
   output logic [ADDR_WIDTH-1:0]   o_p1_req_addr,
   output logic                    o_p1_req_we,
   output logic [DATA_WIDTH-1:0]   o_p1_req_wdata,
   output logic [DATA_WIDTH/8-1:0] o_p1_req_wstrb,
   input  logic                    i_p1_rsp_valid,
   input  logic [DATA_WIDTH-1:0]   i_p1_rsp_rdata,

   output logic                    o_rsp_valid,
   output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
   output logic                    o_err
);

   port_id_t t;
   port_id_t rsp_sel;
   logic     allow;
   logic     allow_q;
   logic     sel_ready;
   logic     fire;
   logic     rsp;

   assign t = i_req_addr[SEL_BIT];

   // Reset blocks issue and response even though the tracker may still
   // hold stale state during the reset cycle.
   assign allow_q   = allow & ~i_rst;
   assign sel_ready = (t == PORT_MMIO) ? i_p1_req_ready : i_p0_req_ready;

   assign o_p0_req_valid = i_req_valid & allow_q & (t == PORT_DMEM);
   assign o_p1_req_valid = i_req_valid & allow_q & (t == PORT_MMIO);
   assign o_req_ready    = allow_q & sel_ready;
   assign fire           = i_req_valid & o_req_ready;

   assign o_p0_req_addr  = i_req_addr;
   assign o_p0_req_we    = i_req_we;
   assign o_p0_req_wdata = i_req_wdata;
   assign o_p0_req_wstrb = i_req_wstrb;

   assign o_p1_req_addr  = i_req_addr;
   assign o_p1_req_we    = i_req_we;
   assign o_p1_req_wdata = i_req_wdata;
   assign o_p1_req_wstrb = i_req_wstrb;

   dmem_outstanding_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_tracker (
      .clk       (i_clk),
      .rst       (i_rst),
      .fire      (fire),
      .t         (t),
      .rsp_valid ({i_p1_rsp_valid, i_p0_rsp_valid}),
      .allow     (allow),
      .rsp_sel   (rsp_sel),
      .rsp       (rsp),
      .err       (o_err)
   );

   always_comb begin
      o_rsp_valid = rsp & ~i_rst;
      o_rsp_rdata = '0;
      if (o_rsp_valid) begin
         o_rsp_rdata = (rsp_sel == PORT_MMIO) ? i_p1_rsp_rdata
                                              : i_p0_rsp_rdata;
      end
   end

   a_one_hot_valid: assert property (
      @(posedge i_clk) !(o_p0_req_valid && o_p1_req_valid));

endmodule

// File: tb/tb_dmem_req_demux_1x2.sv
// Self-checking bench: directed scenarios plus random traffic against
// a queue-based model of in-order ownership and protocol errors.
module tb_dmem_req_demux_1x2;
   import dmem_bus_pkg::*;

   localparam int MAXO = 4;
   localparam int SEL  = 28;

   logic          clk;
   logic          rst;
   logic          req_valid;
   dmem_req_t     req;
   logic          p0_ready, p1_ready;
   logic          p0_rsp_v, p1_rsp_v;
   logic [63:0]   p0_rdata, p1_rdata;

   logic          req_ready;
   logic          p0_v, p1_v;
   logic [63:0]   p0_addr, p1_addr, p0_wdata, p1_wdata;
   logic          p0_we, p1_we;
   logic [7:0]    p0_wstrb, p1_wstrb;
   logic          rsp_v;
   logic [63:0]   rsp_rdata;
   logic          err;

   int n_vec  = 0;
   int n_fail = 0;

   bit q[$];
   bit m_err;
   bit e_fire, e_rsp;
   int scount[2];

   dmem_req_demux_1x2 #(
      .ADDR_WIDTH(64), .DATA_WIDTH(64),
      .SEL_BIT(SEL), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_addr(req.addr), .i_req_we(req.we),
      .i_req_wdata(req.wdata), .i_req_wstrb(req.wstrb),
      .o_p0_req_valid(p0_v), .i_p0_req_ready(p0_ready),
      .o_p0_req_addr(p0_addr), .o_p0_req_we(p0_we),
      .o_p0_req_wdata(p0_wdata), .o_p0_req_wstrb(p0_wstrb),
      .i_p0_rsp_valid(p0_rsp_v), .i_p0_rsp_rdata(p0_rdata),
      .o_p1_req_valid(p1_v), .i_p1_req_ready(p1_ready),
      .o_p1_req_addr(p1_addr), .o_p1_req_we(p1_we),
      .o_p1_req_wdata(p1_wdata), .o_p1_req_wstrb(p1_wstrb),
      .i_p1_rsp_valid(p1_rsp_v), .i_p1_rsp_rdata(p1_rdata),
      .o_rsp_valid(rsp_v), .o_rsp_rdata(rsp_rdata),
      .o_err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Evaluate one cycle: compare against the model, clock, update model.
   task automatic cycle();
      bit          t, allow, e_p0, e_p1, e_rdy;
      bit [1:0]    rv;
      logic [63:0] e_rd;
      #2;
      t     = req.addr[SEL];
      rv    = {p1_rsp_v, p0_rsp_v};
      allow = !rst && (q.size() == 0 ||
                       (t == q[0] && q.size() < MAXO));
      e_p0  = req_valid && allow && (t == 1'b0);
      e_p1  = req_valid && allow && (t == 1'b1);
      e_rdy = allow && (t ? p1_ready : p0_ready);
      e_fire = req_valid && e_rdy;
      e_rsp = !rst && q.size() > 0 && rv[q[0]];
      e_rd  = 64'd0;
      if (e_rsp) e_rd = q[0] ? p1_rdata : p0_rdata;
      chk("p0_valid", p0_v, e_p0);
      chk("p1_valid", p1_v, e_p1);
      chk("req_ready", req_ready, e_rdy);
      chk("rsp_valid", rsp_v, e_rsp);
      chk("rsp_rdata", rsp_rdata, e_rd);
      chk("err", err, m_err);
      chk("p0_addr", p0_addr, req.addr);
      chk("p1_wdata", p1_wdata, req.wdata);
      chk("p1_ctl", {p1_we, p1_wstrb, p0_we, p0_wstrb},
          {req.we, req.wstrb, req.we, req.wstrb});
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_err = 1'b0;
      end else begin
         if (q.size() == 0) begin
            if (rv != 2'b00) m_err = 1'b1;
         end else if (rv[!q[0]]) begin
            m_err = 1'b1;
         end
         if (e_rsp) void'(q.pop_front());
         if (e_fire) q.push_back(t);
      end
      #1;
   endtask

   task automatic set_req(input bit v, input logic [63:0] a,
                          input bit we);
      req_valid = v;
      req.addr  = a;
      req.we    = we;
      req.wdata = {$urandom, $urandom};
      req.wstrb = 8'($urandom);
   endtask

   task automatic set_rsp(input bit v0, input bit v1,
                          input logic [63:0] d);
      p0_rsp_v = v0;
      p1_rsp_v = v1;
      p0_rdata = d;
      p1_rdata = ~d;
   endtask

   initial begin
      rst = 1'b1;
      m_err = 1'b0;
      p0_ready = 1'b1;
      p1_ready = 1'b1;
      set_req(1'b0, 64'd0, 1'b0);
      set_rsp(1'b0, 1'b0, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      set_req(1'b1, 64'h1000, 1'b0);
      cycle();
      rst = 1'b0;
      set_req(1'b0, 64'h0, 1'b0);
      cycle();

      // single read to port 0, response two cycles later
      set_req(1'b1, 64'h0000_1000, 1'b0);
      cycle();
      set_req(1'b0, 64'h0000_1000, 1'b0);
      cycle();
      set_rsp(1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001);
      cycle();
      set_rsp(1'b0, 1'b0, 64'd0);
      cycle();

      // fill port 1, then overflow attempt
      for (int i = 0; i < 5; i++) begin
         set_req(1'b1, 64'h1000_0000 + 64'(8 * i), 1'b1);
         cycle();
      end
      set_rsp(1'b0, 1'b1, 64'h11);
      cycle();
      set_rsp(1'b0, 1'b0, 64'd0);
      cycle();
      set_req(1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         set_rsp(1'b0, 1'b1, 64'(100 + i));
         cycle();
      end
      set_rsp(1'b0, 1'b0, 64'd0);
      cycle();

      // port switch with one bubble
      set_req(1'b1, 64'h2000, 1'b0);
      cycle();
      set_req(1'b1, 64'h1000_0100, 1'b0);
      cycle();
      cycle();
      set_rsp(1'b1, 1'b0, 64'hA5A5);
      cycle();
      set_rsp(1'b0, 1'b0, 64'd0);
      cycle();
      set_req(1'b0, 64'h0, 1'b0);
      cycle();
      set_rsp(1'b0, 1'b1, 64'h5A5A);
      cycle();
      set_rsp(1'b0, 1'b0, 64'd0);

      // simultaneous fire and response at two outstanding
      set_req(1'b1, 64'h3000, 1'b0);
      cycle();
      set_req(1'b1, 64'h3008, 1'b0);
      cycle();
      set_req(1'b1, 64'h3010, 1'b0);
      set_rsp(1'b1, 1'b0, 64'h77);
      cycle();
      set_req(1'b0, 64'h0, 1'b0);
      set_rsp(1'b1, 1'b0, 64'h78);
      cycle();
      cycle();
      set_rsp(1'b0, 1'b0, 64'd0);
      cycle();

      // response from the wrong port
      set_req(1'b1, 64'h4000, 1'b0);
      cycle();
      set_req(1'b0, 64'h0, 1'b0);
      set_rsp(1'b0, 1'b1, 64'h99);
      cycle();
      set_rsp(1'b0, 1'b0, 64'd0);
      cycle();
      set_rsp(1'b1, 1'b0, 64'h9A);
      cycle();
      set_rsp(1'b0, 1'b0, 64'd0);
      cycle();

      // reset with three in flight, then a stale response
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_req(1'b1, 64'h5000 + 64'(8 * i), 1'b0);
         cycle();
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      set_req(1'b0, 64'h0, 1'b0);
      cycle();
      set_rsp(1'b1, 1'b0, 64'hBAD);
      cycle();
      set_rsp(1'b0, 1'b0, 64'd0);
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;

      // random well-behaved traffic from two in-order slaves
      scount[0] = 0;
      scount[1] = 0;
      for (int n = 0; n < 2000; n++) begin
         bit t;
         rst = ($urandom_range(0, 199) == 0);
         set_req($urandom_range(0, 2) != 0,
                 {$urandom, $urandom}, 1'($urandom));
         p0_ready = ($urandom_range(0, 3) != 0);
         p1_ready = ($urandom_range(0, 3) != 0);
         set_rsp(!rst && scount[0] > 0 && $urandom_range(0, 1) == 1,
                 !rst && scount[1] > 0 && $urandom_range(0, 1) == 1,
                 {$urandom, $urandom});
         t = req.addr[SEL];
         cycle();
         if (rst) begin
            scount[0] = 0;
            scount[1] = 0;
         end else begin
            if (p0_rsp_v) scount[0]--;
            if (p1_rsp_v) scount[1]--;
            if (e_fire) scount[t]++;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_req_demux_1x2.md
Name: dmem_req_demux_1x2

Overview:
- Steers the core's single data-memory request stream to one of two downstream targets, port 0 or port 1 (e.g. DMEM and MMIO), selected by one address bit.
- Merges the two response streams back into one in-order response stream.
- Tracks outstanding transactions so responses always return in request order.
- Sits between the load/store unit and the memory/peripheral slaves of the 64-bit core.

Parameters:
- ADDR_WIDTH, 64, request address width.
- DATA_WIDTH, 64, read/write data width; strobe width is DATA_WIDTH/8.
- SEL_BIT, 28, address bit index selecting the target (0 → port 0, 1 → port 1).
- MAX_OUTSTANDING, 4, maximum in-flight requests; must be ≥1.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req_valid  input  1  upstream request valid.
- o_req_ready  output  1  upstream request accepted this cycle.
- i_req_addr  input  ADDR_WIDTH  request address.
- i_req_we  input  1  1 = write, 0 = read.
- i_req_wdata  input  DATA_WIDTH  write data.
- i_req_wstrb  input  DATA_WIDTH/8  byte strobes.
- o_pN_req_valid  output  1  request valid to port N (N = 0, 1).
- i_pN_req_ready  input  1  port N accepts.
- o_pN_req_addr / o_pN_req_we / o_pN_req_wdata / o_pN_req_wstrb  output  as upstream  request payload to port N.
- i_pN_rsp_valid  input  1  port N response valid; exactly one response per request, reads and writes alike.
- i_pN_rsp_rdata  input  DATA_WIDTH  port N read data.
- o_rsp_valid  output  1  merged response valid; upstream has no backpressure.
- o_rsp_rdata  output  DATA_WIDTH  merged read data.
- o_err  output  1  sticky protocol-error flag.

Behaviour:
- State registers:
  - cnt: outstanding count, range 0..MAX_OUTSTANDING.
  - own: 1-bit port that owns the outstanding requests.
  - err: sticky error bit.
- Target: t = i_req_addr[SEL_BIT].
- Issue allowed (allow) when cnt == 0, or when (t == own and cnt < MAX_OUTSTANDING).
  - Requests to the non-owning port stall until cnt reaches 0. This makes cross-port reordering impossible without buffering.
- Request path (combinational, zero latency):
  - o_pt_req_valid = i_req_valid & allow.
  - The other port's valid is 0.
  - Payload is driven unchanged to both ports.
  - o_req_ready = allow & i_pt_req_ready.
  - A request may not depend on ready: valid is asserted regardless of downstream ready.
- fire = i_req_valid & o_req_ready. On fire, own <= t.
- Response path (combinational, zero latency):
  - rsp = i_own_rsp_valid & (cnt != 0).
  - o_rsp_valid = rsp.
  - o_rsp_rdata = i_own_rsp_rdata when rsp, else 0.
- Counter update: cnt <= cnt + fire − rsp.
  - Simultaneous fire and rsp leaves cnt unchanged.
- Switching ports: when cnt == 1, a response arrives, and the pending request targets the other port, the request is not issued that cycle. allow uses the registered cnt, so exactly one bubble is inserted.
- Full: at cnt == MAX_OUTSTANDING, o_req_ready = 0 even to the owner.
  - A same-cycle response does not re-open ready in that cycle.
- Protocol error: any of the following sets err, which holds until reset. The offending response is dropped (no o_rsp_valid, cnt unaffected).
  - i_pN_rsp_valid for N != own while cnt > 0.
  - Any i_pN_rsp_valid while cnt == 0.
- o_err = err.
- Reset (synchronous, i_rst high at a rising edge):
  - cnt = 0, own = 0, err = 0.
  - While i_rst is high: o_req_ready = 0, o_p0_req_valid = o_p1_req_valid = 0, o_rsp_valid = 0, o_rsp_rdata = 0.
  - Reset mid-transaction discards all outstanding tracking; late responses arriving after reset flag o_err.
- Assertions: cnt never exceeds MAX_OUTSTANDING; both o_pN_req_valid are never high together.

Decomposition:
- Shared package dmem_bus_pkg:
  - typedef port_id_t (1 bit).
  - Constants PORT_DMEM = 0 and PORT_MMIO = 1.
  - Request struct dmem_req_t {addr, we, wdata, wstrb}, parameterised via package constants XLEN = 64 and STRB_W = XLEN/8.
- One natural sub-module: dmem_outstanding_tracker.
  - Holds cnt, own and err.
  - Inputs: fire, t, and both rsp_valid bits.
  - Outputs: allow, rsp_sel, err.
- The top level keeps the combinational steering only.

Test Plan:
- Single read to port 0: addr 0x0000_1000, p0 ready, p0 responds 2 cycles later with rdata 0xDEAD_BEEF_0000_0001 → o_rsp_valid for 1 cycle with that data; cnt returns to 0; p1 valid never asserted.
- Four back-to-back writes to port 1 (addr bit 28 set, 0x1000_0000..0x1000_0018), responses withheld → 4 accepted, 5th request sees o_req_ready = 0; one response releases it the next cycle.
- Port switch: read to p0 outstanding, next request to p1 → p1 valid stays 0 until p0 responds; issue happens the cycle after the response (one bubble); responses return in order p0 then p1.
- Simultaneous fire and response on owner port at cnt = 2 → cnt stays 2; o_rsp_valid and o_p0_req_valid both high in the same cycle.
- Protocol error: response on p1 while own = 0 and cnt = 1 → o_err rises the next cycle and stays high; o_rsp_valid stays 0; cnt stays 1.
- Reset mid-operation: assert i_rst with cnt = 3 → next cycle cnt = 0, o_err = 0, o_req_ready = 0 during reset; a stale p0 response after reset release sets o_err.
